// File: rtl/decode_queue.sv
// decode_queue: multi-lane RV32I decode stage feeding a circular instruction queue.
//
// Ports:
//   clock, reset (sync, active-high), flush   - control
//   in_valid/in_line/in_pc/in_ready           - LANES-wide fetch side
//   out_valid/out_ready/out_pc                - issue handshake, one record per cycle
//   instr_type, branch_type, branch_unsigned,
//   load_type, load_unsigned, rs1, rs2, rd,
//   imm                                       - decoded head record
//   count                                     - current occupancy
module decode_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [LANES-1:0]      in_valid,
    input  logic [32*LANES-1:0]   in_line,
    input  logic [32*LANES-1:0]   in_pc,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [12:0]           instr_type,
    output logic [1:0]            branch_type,
    output logic                  branch_unsigned,
    output logic [2:0]            load_type,
    output logic                  load_unsigned,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic [31:0]           imm,
    output logic [CW-1:0]         count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [12:0] itype;
        logic [1:0]  bt;
        logic        bu;
        logic [2:0]  lt;
        logic        lu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } rec_t;

    function automatic rec_t decode(input logic [31:0] w, input logic [31:0] pc);
        rec_t        r;
        logic [12:0] t;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
        f3       = w[14:12];
        f7       = w[31:25];
        r        = '0;
        r.pc     = pc;
        r.rs1    = w[19:15];
        r.rs2    = w[24:20];
        r.rd     = w[11:7];
        r.bt     = {f3[2], f3[0]};
        r.bu     = f3[2] & f3[1];
        r.lu     = f3[2];
        unique case (f3[1:0])
            2'd0:    r.lt = 3'b001;
            2'd1:    r.lt = 3'b010;
            2'd2:    r.lt = 3'b100;
            default: r.lt = 3'b000;
        endcase
        t = '0;
        unique case (w[6:0])
            7'h33:   t[0]  = (f7 == 7'h00) || (f7 == 7'h20);
            7'h13:   t[1]  = 1'b1;
            7'h6F:   t[2]  = 1'b1;
            7'h67:   t[3]  = 1'b1;
            7'h63:   t[4]  = (f3 != 3'd2) && (f3 != 3'd3);
            7'h03:   t[5]  = (f3 != 3'd3) && (f3 < 3'd6);
            7'h23:   t[6]  = (f3 <= 3'd2);
            7'h37:   t[10] = 1'b1;
            7'h17:   t[11] = 1'b1;
            default: t     = '0;
        endcase
        // Any class bit surviving its funct checks makes the word legal.
        ill   = ~|{t[11:10], t[6:0]};
        t[7]  = (t[0] && (f7 == 7'h20)) || t[4];
        t[8]  = ~(t[6] | t[4] | ill | (r.rd == 5'd0));
        t[9]  = t[0] | t[4] | t[6];
        t[12] = ill;
        r.itype = t;
        unique case (1'b1)
            t[1] | t[3] | t[5]: r.imm = {{20{w[31]}}, w[31:20]};
            t[6]:  r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            t[4]:  r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            t[2]:  r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            t[10] | t[11]: r.imm = {w[31:12], 12'h000};
            default: r.imm = '0;
        endcase
        return r;
    endfunction

    rec_t            mem_q [DEPTH];
    rec_t            dec   [LANES];
    rec_t            head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   n_acc;
    logic            run;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            dec[i] = decode(in_line[32*i +: 32], in_pc[32*i +: 32]);
        end
    end

    // Only the unbroken run of valid lanes starting at lane 0 is taken.
    always_comb begin
        n_acc = '0;
        run   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run = run & in_valid[i];
            if (run) n_acc = n_acc + CW'(1);
        end
    end

    assign in_ready  = count_q <= CW'(DEPTH - LANES);
    assign out_valid = count_q != '0;
    assign do_push   = in_ready && !flush;
    assign do_pop    = out_valid && out_ready && !flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            count_d  = count_d + n_acc;
            wr_ptr_d = wr_ptr_q + AW'(n_acc);
        end
        if (do_pop) begin
            count_d  = count_d - CW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            for (int i = 0; i < LANES; i++) begin
                if (CW'(i) < n_acc) mem_q[wr_ptr_q + AW'(i)] <= dec[i];
            end
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign out_pc          = head.pc;
    assign instr_type      = head.itype;
    assign branch_type     = head.bt;
    assign branch_unsigned = head.bu;
    assign load_type       = head.lt;
    assign load_unsigned   = head.lu;
    assign rs1             = head.rs1;
    assign rs2             = head.rs2;
    assign rd              = head.rd;
    assign imm             = head.imm;
    assign count           = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed and random stimulus for decode_queue, with a
// queue-based reference model and a decoupled output monitor.
module tb_decode_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [12:0] itype;
        logic [1:0]  bt;
        logic        bu;
        logic [2:0]  lt;
        logic        lu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                flush = 1'b0;
    logic [LANES-1:0]    in_valid = '0;
    logic [32*LANES-1:0] in_line = '0;
    logic [32*LANES-1:0] in_pc = '0;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [31:0]         out_pc;
    logic [12:0]         instr_type;
    logic [1:0]          branch_type;
    logic                branch_unsigned;
    logic [2:0]          load_type;
    logic                load_unsigned;
    logic [4:0]          rs1, rs2, rd;
    logic [31:0]         imm;
    logic [CW-1:0]       count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    bit   pend = 0;
    bit   live = 0;
    logic [31:0] pc_ctr = 32'h1000;
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h6F, 7'h67, 7'h63,
                             7'h03, 7'h23, 7'h37, 7'h17};

    decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_line(in_line), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .instr_type(instr_type),
        .branch_type(branch_type), .branch_unsigned(branch_unsigned),
        .load_type(load_type), .load_unsigned(load_unsigned),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference decode written from the instruction-format rules.
    function automatic exp_t m_dec(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic reg_, imm_, jal, jalr, br, ld, st, lui, aui, sub, ill;
        f3 = w[14:12];
        f7 = w[31:25];
        {reg_, imm_, jal, jalr, br, ld, st, lui, aui, sub, ill} = '0;
        e.imm = 0;
        case (w[6:0])
            7'h33: if (f7 == 7'h00 || f7 == 7'h20) begin
                reg_ = 1; sub = (f7 == 7'h20);
            end else ill = 1;
            7'h13: begin imm_ = 1; e.imm = {{20{w[31]}}, w[31:20]}; end
            7'h67: begin jalr = 1; e.imm = {{20{w[31]}}, w[31:20]}; end
            7'h6F: begin
                jal = 1;
                e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h63: if (f3 == 2 || f3 == 3) ill = 1;
            else begin
                br = 1; sub = 1;
                e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h03: if (f3 == 3 || f3 >= 6) ill = 1;
            else begin ld = 1; e.imm = {{20{w[31]}}, w[31:20]}; end
            7'h23: if (f3 > 2) ill = 1;
            else begin st = 1; e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
            7'h37: begin lui = 1; e.imm = {w[31:12], 12'h0}; end
            7'h17: begin aui = 1; e.imm = {w[31:12], 12'h0}; end
            default: ill = 1;
        endcase
        e.pc  = pc;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        e.itype = '0;
        e.itype[0]  = reg_;
        e.itype[1]  = imm_;
        e.itype[2]  = jal;
        e.itype[3]  = jalr;
        e.itype[4]  = br;
        e.itype[5]  = ld;
        e.itype[6]  = st;
        e.itype[7]  = sub;
        e.itype[8]  = !(st || br || ill) && (e.rd != 0);
        e.itype[9]  = reg_ || br || st;
        e.itype[10] = lui;
        e.itype[11] = aui;
        e.itype[12] = ill;
        e.bt = {f3[2], f3[0]};
        e.bu = f3[2] && f3[1];
        e.lt = (f3[1:0] == 0) ? 3'b001 : (f3[1:0] == 1) ? 3'b010 : 3'b100;
        e.lu = f3[2];
        return e;
    endfunction

    // Model: tracks occupancy as the scoreboard length.
    initial forever begin
        int pre;
        @(posedge clock);
        if (reset || flush) sb.delete();
        else begin
            pre = sb.size() + (pend ? 1 : 0);
            if (DEPTH - pre >= LANES) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!in_valid[i]) break;
                    sb.push_back(m_dec(in_line[32*i +: 32], in_pc[32*i +: 32]));
                end
            end
        end
        pend = 0;
    end

    // Monitor: compares status every cycle and pops on each handshake.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (live) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(DEPTH - sb.size() >= LANES));
            if (!reset && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(out_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    pend = 1;
                    chk("pc", out_pc, e.pc);
                    chk("itype", 32'(instr_type), 32'(e.itype));
                    chk("rs1", 32'(rs1), 32'(e.rs1));
                    chk("rs2", 32'(rs2), 32'(e.rs2));
                    chk("rd", 32'(rd), 32'(e.rd));
                    chk("imm", imm, e.imm);
                    if (e.itype[4]) begin
                        chk("btype", 32'(branch_type), 32'(e.bt));
                        chk("bunsig", 32'(branch_unsigned), 32'(e.bu));
                    end
                    if (e.itype[5]) begin
                        chk("ltype", 32'(load_type), 32'(e.lt));
                        chk("lunsig", 32'(load_unsigned), 32'(e.lu));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [1:0] v);
        in_line  = {w1, w0};
        in_pc    = {pc_ctr + 32'd4, pc_ctr};
        pc_ctr   = pc_ctr + 32'd8;
        in_valid = v;
    endtask

    task automatic push(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [1:0] v);
        drive(w0, w1, v);
        tick();
        in_valid = '0;
    endtask

    task automatic pop1();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic drain();
        out_ready = 1;
        in_valid  = '0;
        for (int i = 0; i < 4 * DEPTH && count != 0; i++) tick();
        out_ready = 0;
        chk("drain", 32'(count), 32'(0));
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = ops[k];
        if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        reset = 1;
        tick(); tick();
        live  = 1;
        reset = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);

        push(32'h00500093, 32'h00108133, 2'b11);
        chk("d_valid", 32'(out_valid), 1);
        chk("d_imm_cls", 32'(instr_type[1]), 1);
        chk("d_imm", imm, 5);
        chk("d_rd", 32'(rd), 1);
        chk("d_wrd", 32'(instr_type[8]), 1);
        chk("d_count", 32'(count), 2);
        pop1();
        chk("d_reg", 32'(instr_type[0]), 1);
        chk("d_rs1", 32'(rs1), 1);
        chk("d_rs2", 32'(rs2), 1);
        chk("d_rd2", 32'(rd), 2);
        chk("d_urs2", 32'(instr_type[9]), 1);
        chk("d_imm0", imm, 0);
        drain();

        for (int i = 0; i < 4; i++) begin
            push(gen(), gen(), 2'b11);
            chk("f_count", 32'(count), 32'(2 * (i + 1)));
            chk("f_ready", 32'(in_ready), 32'(i < 3));
        end
        push(gen(), gen(), 2'b11);
        chk("f_hold", 32'(count), 8);
        out_ready = 1;
        tick(); tick();
        drive(gen(), gen(), 2'b11);
        tick();
        in_valid  = '0;
        out_ready = 0;
        chk("w_count", 32'(count), 7);
        drain();

        push(32'h123452B7, 32'h40208133, 2'b11);
        push(32'h0000007F, 32'h0020E463, 2'b11);
        chk("lui", 32'(instr_type[10]), 1);
        chk("lui_rd", 32'(rd), 5);
        chk("lui_imm", imm, 32'h12345000);
        pop1();
        chk("sub", 32'(instr_type[7]), 1);
        pop1();
        chk("ill", 32'(instr_type[12]), 1);
        chk("ill_wrd", 32'(instr_type[8]), 0);
        chk("ill_imm", imm, 0);
        pop1();
        chk("bltu_bt", 32'(branch_type), 2);
        chk("bltu_bu", 32'(branch_unsigned), 1);
        pop1();

        push(gen(), gen(), 2'b11);
        push(gen(), gen(), 2'b11);
        push(gen(), gen(), 2'b01);
        chk("fl_pre", 32'(count), 5);
        drive(gen(), gen(), 2'b11);
        flush = 1; out_ready = 1;
        tick();
        flush = 0; out_ready = 0; in_valid = '0;
        chk("fl_count", 32'(count), 0);
        chk("fl_valid", 32'(out_valid), 0);
        chk("fl_ready", 32'(in_ready), 1);

        push(gen(), gen(), 2'b11);
        push(gen(), gen(), 2'b01);
        chk("r_pre", 32'(count), 3);
        drive(gen(), gen(), 2'b11);
        reset = 1; out_ready = 1;
        tick();
        reset = 0; out_ready = 0; in_valid = '0;
        chk("r_count", 32'(count), 0);
        chk("r_valid", 32'(out_valid), 0);
        push(gen(), gen(), 2'b10);
        chk("gap", 32'(count), 0);

        for (int i = 0; i < 2000; i++) begin
            drive(gen(), gen(), 2'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 49) == 0;
            reset     = $urandom_range(0, 199) == 0;
            tick();
        end
        flush = 0; reset = 0;
        drain();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
